// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART command parser slice.
//   - state_t          : frame decoder states (IDLE, ADDR, DH, DL, CHK)
//   - SYNC_BYTE_DEFAULT : default frame start marker
//   - calc_timeout_clks : converts an inter-byte gap in byte times into clocks
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DH   = 3'd2,
    ST_DL   = 3'd3,
    ST_CHK  = 3'd4
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // One byte on the line is 10 bit times (start + 8 data + stop). The
  // clocks-per-bit ratio is truncated first, so the result is a whole number
  // of truncated bit periods (50 MHz / 115200 -> 434, 4 bytes -> 17360).
  function automatic int unsigned calc_timeout_clks(
    input int unsigned freq,
    input int unsigned baud,
    input int unsigned bytes
  );
    return bytes * 10 * (freq / baud);
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// uart_cmd_parser_if: byte-stream input and register-write output of the
// UART command parser bundled into one interface.
//   rdata/vld        : byte stream from the UART receiver (vld is a 1-cycle pulse)
//   wr_en/addr/data  : single-cycle register write towards the register file
//   frm_err          : 1-cycle pulse on checksum mismatch or inter-byte timeout
//   busy             : a frame is being collected
//   good_cnt/err_cnt : frame statistics, present only with UART_CMD_PARSER_STATS_EN
// Modports: slave = the parser, master = the environment driving it.
interface uart_cmd_parser_if;
  logic [7:0]  rdata;
  logic        vld;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        frm_err;
  logic        busy;
`ifdef UART_CMD_PARSER_STATS_EN
  logic [15:0] good_cnt;
  logic [15:0] err_cnt;
`endif

  modport slave (
    input  rdata, vld,
    output wr_en, wr_addr, wr_data, frm_err, busy
`ifdef UART_CMD_PARSER_STATS_EN
    , output good_cnt, err_cnt
`endif
  );

  modport master (
    output rdata, vld,
    input  wr_en, wr_addr, wr_data, frm_err, busy
`ifdef UART_CMD_PARSER_STATS_EN
    , input good_cnt, err_cnt
`endif
  );
endinterface

// File: rtl/uart_gap_timer.sv
// uart_gap_timer: counts clocks since the last received byte of a frame.
//   clk, nrst : clock, asynchronous active-low reset
//   clr       : restart the count at 0 (byte received, or parser idle)
//   en        : count this cycle (parser inside a frame)
//   expire    : high during the last allowed gap cycle (count == TO-1, no clr)
// The counter saturates at TO-1 so it never wraps if the parser lingers.
module uart_gap_timer #(
  parameter int unsigned TO = 17360
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned W = (TO > 1) ? $clog2(TO) : 1;
  localparam logic [W-1:0] LAST = W'(TO - 32'd1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // clr covers a byte arriving on the expiry cycle: the byte wins.
  assign expire = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: decodes 5-byte register-write frames
//   SYNC, ADDR, DATA_H, DATA_L, CHK (CHK = ADDR ^ DATA_H ^ DATA_L)
// from the UART receiver byte stream and issues a single-cycle write.
// Ports:
//   clk, nrst : clock, asynchronous active-low reset
//   bus       : uart_cmd_parser_if.slave (rdata/vld in; wr_en, wr_addr,
//               wr_data, frm_err, busy out; good_cnt/err_cnt when the
//               UART_CMD_PARSER_STATS_EN macro is defined)
// wr_en / frm_err appear one clock after the CHK byte; an inter-byte gap of
// TO clocks abandons the frame and pulses frm_err.
module uart_cmd_parser
  import uart_pkg::*;
#(
  parameter int unsigned BAUDRATE      = 115200,
  parameter int unsigned FREQ          = 50_000_000,
  parameter logic [7:0]  SYNC_BYTE     = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_BYTES = 4
) (
  input logic             clk,
  input logic             nrst,
  uart_cmd_parser_if.slave bus
);

  localparam int unsigned TO = calc_timeout_clks(FREQ, BAUDRATE, TIMEOUT_BYTES);

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  dh_q, dh_d;
  logic [7:0]  dl_q, dl_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        frm_err_q, frm_err_d;
  logic        gap_expire;

  uart_gap_timer #(
    .TO(TO)
  ) u_gap_timer (
    .clk    (clk),
    .nrst   (nrst),
    .clr    (bus.vld || (state_q == ST_IDLE)),
    .en     (state_q != ST_IDLE),
    .expire (gap_expire)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    dh_d      = dh_q;
    dl_d      = dl_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    frm_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.vld && (bus.rdata == SYNC_BYTE)) begin
          state_d = ST_ADDR;
        end
      end
      // A SYNC value inside a frame is plain data: no resync.
      ST_ADDR: begin
        if (bus.vld) begin
          addr_d  = bus.rdata;
          state_d = ST_DH;
        end
      end
      ST_DH: begin
        if (bus.vld) begin
          dh_d    = bus.rdata;
          state_d = ST_DL;
        end
      end
      ST_DL: begin
        if (bus.vld) begin
          dl_d    = bus.rdata;
          state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        if (bus.vld) begin
          if (bus.rdata == (addr_q ^ dh_q ^ dl_q)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = {dh_q, dl_q};
          end else begin
            frm_err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // gap_expire is already suppressed by vld, so it never collides with a
    // byte being processed above.
    if (gap_expire) begin
      state_d   = ST_IDLE;
      frm_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      dh_q      <= '0;
      dl_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      dh_q      <= dh_d;
      dl_q      <= dl_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      frm_err_q <= frm_err_d;
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.frm_err = frm_err_q;
  assign bus.busy    = (state_q != ST_IDLE);

`ifdef UART_CMD_PARSER_STATS_EN
  logic [15:0] good_cnt_q, good_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Counted off the registered pulses, so each lands one clock after its strobe.
  always_comb begin
    good_cnt_d = good_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (wr_en_q && (good_cnt_q != 16'hFFFF)) begin
      good_cnt_d = good_cnt_q + 16'd1;
    end
    if (frm_err_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      good_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      good_cnt_q <= good_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.good_cnt = good_cnt_q;
  assign bus.err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Testbench for uart_cmd_parser: directed frames, scoreboard of expected
// wr_en / frm_err events (with the exact cycle they must appear), and a
// monitor that pops and compares whenever the DUT pulses an output.
module tb_uart_cmd_parser;

  localparam int TO = 17360;   // 4 * 10 * (50_000_000 / 115200)

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_cmd_parser_if bus ();

  uart_cmd_parser dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  typedef struct {
    bit          is_wr;
    logic [7:0]  addr;
    logic [15:0] data;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   last_cyc = 0;
  logic [7:0]  model_addr = 8'h00;
  logic [15:0] model_data = 16'h0000;
  int   model_good = 0;
  int   model_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end else begin
      $display("[TB] ok   %s = %h", name, act);
    end
  endtask

  // Drive one byte at the current negedge; returns positioned one negedge later.
  task automatic send(input logic [7:0] b);
    bus.vld   = 1'b1;
    bus.rdata = b;
    last_cyc  = cyc;
    @(negedge clk);
    bus.vld   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [15:0] d, input int at);
    exp_t e;
    e.is_wr = 1'b1; e.addr = a; e.data = d; e.at = at;
    exp_q.push_back(e);
    model_addr = a;
    model_data = d;
    model_good++;
  endtask

  task automatic push_err(input int at);
    exp_t e;
    e.is_wr = 1'b0; e.addr = 8'h00; e.data = 16'h0000; e.at = at;
    exp_q.push_back(e);
    model_err++;
  endtask

  // Five-byte frame, gap idle cycles after each byte. good/addr/data are hand-given.
  task automatic frame(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l,
                       input logic [7:0] c, input int gap, input bit good,
                       input logic [7:0] ea, input logic [15:0] ed);
    send(8'hA5); idle(gap);
    send(a);     idle(gap);
    send(h);     idle(gap);
    send(l);     idle(gap);
    send(c);
    if (good) push_wr(ea, ed, last_cyc + 1);
    else      push_err(last_cyc + 1);
    idle(gap);
  endtask

  // Monitor: one line per output event.
  exp_t mon_e;
  bit   mon_ok;
  always @(negedge clk) begin
    if (nrst && (bus.wr_en || bus.frm_err)) begin
      tests++;
      if (bus.wr_en && bus.frm_err) begin
        fails++;
        $display("[TB] FAIL excl: wr_en=1 frm_err=1 at cyc %0d, expected only one", cyc);
      end else if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected: wr_en=%b frm_err=%b addr=%h data=%h at cyc %0d, expected none",
                 bus.wr_en, bus.frm_err, bus.wr_addr, bus.wr_data, cyc);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_ok = (bus.wr_en == mon_e.is_wr) && (cyc == mon_e.at) && !bus.busy &&
                 (!mon_e.is_wr || ((bus.wr_addr == mon_e.addr) && (bus.wr_data == mon_e.data)));
        if (!mon_ok) begin
          fails++;
          $display("[TB] FAIL event: got wr=%b addr=%h data=%h busy=%b cyc=%0d, expected wr=%b addr=%h data=%h busy=0 cyc=%0d",
                   bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, cyc,
                   mon_e.is_wr, mon_e.addr, mon_e.data, mon_e.at);
        end else begin
          $display("[TB] event %s addr=%h data=%h cyc=%0d", mon_e.is_wr ? "wr " : "err",
                   bus.wr_addr, bus.wr_data, cyc);
        end
      end
    end
  end

  initial begin
    bus.vld   = 1'b0;
    bus.rdata = 8'h00;
    @(negedge clk);
    idle(3);
    chk("rst_wr_en",   {31'd0, bus.wr_en},   32'd0);
    chk("rst_frm_err", {31'd0, bus.frm_err}, 32'd0);
    chk("rst_busy",    {31'd0, bus.busy},    32'd0);
    chk("rst_wr_addr", {24'd0, bus.wr_addr}, 32'd0);
    chk("rst_wr_data", {16'd0, bus.wr_data}, 32'd0);
    nrst = 1'b1;
    idle(2);

    // Good frame at the nominal byte spacing.
    send(8'hA5); idle(4339);
    chk("busy_in_frame", {31'd0, bus.busy}, 32'd1);
    frame_tail_good: begin
      send(8'h12); idle(4339);
      send(8'h34); idle(4339);
      send(8'h56); idle(4339);
      send(8'h70);
      push_wr(8'h12, 16'h3456, last_cyc + 1);
    end
    idle(4);

    // Bad checksum: write registers must hold.
    frame(8'h12, 8'h34, 8'h56, 8'h71, 2, 1'b0, 8'h00, 16'h0000);
    idle(3);
    chk("hold_addr", {24'd0, bus.wr_addr}, {24'd0, 8'h12});
    chk("hold_data", {16'd0, bus.wr_data}, {16'd0, 16'h3456});

    // Leading garbage, then A5 used as ADDR.
    send(8'h00); idle(1);
    send(8'hFF); idle(1);
    frame(8'hA5, 8'h00, 8'h01, 8'hA4, 1, 1'b1, 8'hA5, 16'h0001);
    idle(3);

    // Timeout after A5 12.
    send(8'hA5);
    send(8'h12);
    push_err(last_cyc + 1 + TO);
    idle(TO - 1);
    chk("busy_before_expiry", {31'd0, bus.busy}, 32'd1);
    idle(3);
    chk("busy_after_timeout", {31'd0, bus.busy}, 32'd0);
    frame(8'h01, 8'h02, 8'h03, 8'h00, 1, 1'b1, 8'h01, 16'h0203);
    idle(3);

    // Byte landing exactly on the expiry cycle is accepted.
    send(8'hA5);
    send(8'h12);
    idle(TO - 1);
    send(8'h34);
    send(8'h56);
    send(8'h70);
    push_wr(8'h12, 16'h3456, last_cyc + 1);
    idle(4);

    // Reset mid-frame.
    send(8'hA5); send(8'h12); send(8'h34);
    nrst = 1'b0;
    idle(1);
    chk("mid_rst_busy",    {31'd0, bus.busy},    32'd0);
    chk("mid_rst_wr_addr", {24'd0, bus.wr_addr}, 32'd0);
    chk("mid_rst_wr_data", {16'd0, bus.wr_data}, 32'd0);
    model_addr = 8'h00; model_data = 16'h0000;
    model_good = 0; model_err = 0;
    idle(2);
    nrst = 1'b1;
    idle(2);
    chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);

    // Back-to-back: second SYNC one clock after the first CHK.
    frame(8'hAB, 8'hCD, 8'hEF, 8'h89, 0, 1'b1, 8'hAB, 16'hCDEF);
    frame(8'h01, 8'h00, 8'hFF, 8'hFE, 0, 1'b1, 8'h01, 16'h00FF);
    idle(3);
    chk("b2b_wr_addr", {24'd0, bus.wr_addr}, {24'd0, 8'h01});
    chk("b2b_wr_data", {16'd0, bus.wr_data}, {16'd0, 16'h00FF});

    // Third good and two bad frames since reset.
    frame(8'h10, 8'h20, 8'h30, 8'h00, 1, 1'b1, 8'h10, 16'h2030);
    frame(8'h00, 8'h00, 8'h00, 8'h01, 1, 1'b0, 8'h00, 16'h0000);
    frame(8'hFF, 8'h00, 8'h00, 8'h00, 1, 1'b0, 8'h00, 16'h0000);
    idle(10);
    chk("final_wr_addr", {24'd0, bus.wr_addr}, {24'd0, model_addr});
    chk("final_wr_data", {16'd0, bus.wr_data}, {16'd0, model_data});
    chk("scoreboard_drained", exp_q.size(), 32'd0);
`ifdef UART_CMD_PARSER_STATS_EN
    chk("good_cnt", {16'd0, bus.good_cnt}, 32'd3);
    chk("err_cnt",  {16'd0, bus.err_cnt},  32'd2);
    chk("good_cnt_model", {16'd0, bus.good_cnt}, model_good);
    chk("err_cnt_model",  {16'd0, bus.err_cnt},  model_err);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART receiver.
- Consumes its byte stream (8-bit data plus 1-cycle valid pulse) and decodes fixed 5-byte register-write frames: SYNC, ADDR, DATA_H, DATA_L, CHK.
- On a good frame, issues a single-cycle register write to the local register file.
- Flags checksum and inter-byte timeout errors.

Parameters:
- BAUDRATE, 115200, line rate; used only for timeout sizing.
- FREQ, 50_000_000, clk frequency in Hz.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_BYTES, 4, allowed inter-byte gap in byte times. Timeout clocks TO = TIMEOUT_BYTES*10*(FREQ/BAUDRATE), integer division. Default is 17360.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- rdata  in  8  received byte; valid only while vld=1
- vld  in  1  1-cycle pulse per received byte
- wr_en  out  1  1-cycle register write strobe
- wr_addr  out  8  write address
- wr_data  out  16  write data {DATA_H, DATA_L}
- frm_err  out  1  1-cycle pulse on checksum mismatch or timeout
- busy  out  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset: nrst is asynchronous, active-low; clock is clk. All outputs reset to 0; state resets to IDLE; the gap counter resets to 0.
- States: IDLE, ADDR, DH, DL, CHK. Transitions occur only on a clk edge where vld=1, except the timeout.
- IDLE:
  - vld with rdata==SYNC_BYTE -> ADDR.
  - Any other byte is discarded; state stays IDLE.
- ADDR, DH, DL: on vld, capture rdata into the addr / dh / dl holding registers and advance to the next state.
- CHK, on vld:
  - Expected checksum = addr ^ dh ^ dl (8-bit XOR).
  - Match: the next cycle drives wr_en=1, wr_addr=addr, wr_data={dh,dl}.
  - Mismatch: the next cycle drives frm_err=1.
  - Either way, go to IDLE.
- Latency: wr_en / frm_err rise exactly 1 clk after the vld edge of the CHK byte.
- wr_addr / wr_data update only with wr_en and hold their value until the next good frame.
- A SYNC_BYTE value received in ADDR/DH/DL/CHK is treated as ordinary data; there is no mid-frame resync.
- Gap counter:
  - Clears on every vld and whenever the state is IDLE.
  - Otherwise increments by 1 per clk, saturating.
  - Counter == TO-1 with no vld that cycle -> go to IDLE and pulse frm_err next cycle.
  - vld in the same cycle as expiry: vld wins. The byte is processed and the counter clears.
- Back-to-back frames: the SYNC of the next frame may arrive any cycle after the CHK vld, including while wr_en is high. It is accepted normally.
- wr_en and frm_err are mutually exclusive, and each is at most 1 cycle per frame.
- Reset mid-frame: frame abandoned; no wr_en and no frm_err are emitted.

Optional Feature:
- Macro: UART_CMD_PARSER_STATS_EN.
- When defined:
  - Adds output ports good_cnt[15:0] and err_cnt[15:0], both reset to 0.
  - good_cnt increments with each wr_en; err_cnt increments with each frm_err.
  - Both saturate at 16'hFFFF.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding for IDLE/ADDR/DH/DL/CHK;
  - the default SYNC_BYTE constant;
  - a function computing TO from FREQ, BAUDRATE and TIMEOUT_BYTES.
- One natural sub-module: uart_gap_timer (clear input, enable input, expiry pulse output, TO parameter).
- The FSM and the output registers stay in the top level.

Test Plan:
- Good frame: bytes A5 12 34 56 70, each as a vld pulse 4340 clk apart -> exactly one wr_en pulse 1 clk after the last vld, with wr_addr=0x12, wr_data=0x3456; frm_err stays 0; busy falls the same cycle.
- Bad checksum: A5 12 34 56 71 -> one frm_err pulse; no wr_en; wr_addr/wr_data keep their previous values.
- Leading garbage and embedded sync:
  - 00 FF A5 A5 00 01 A4 -> garbage ignored. Second A5 is taken as ADDR=0xA5, so DH=00, DL=01, CHK=A4 -> wr_addr=0xA5, wr_data=0x0001.
- Timeout:
  - A5 12, then no vld for 17360 clk -> frm_err pulse, busy=0.
  - A following good frame A5 01 02 03 00 -> wr_addr=0x01, wr_data=0x0203.
  - A vld landing exactly on the expiry cycle is accepted with no error.
- Reset mid-frame and back-to-back:
  - Assert nrst low after A5 12 34 -> all outputs 0, no pulses.
  - After release, two back-to-back good frames with the second SYNC 1 clk after the first CHK -> two wr_en pulses with correct addr/data.
- With UART_CMD_PARSER_STATS_EN defined: a run of 3 good and 2 bad frames -> good_cnt=3, err_cnt=2.
